// File: rtl/prog_loader.sv
// Boot-time program loader.
// Takes a byte stream (16-bit little-endian word count, then little-endian
// instruction words) over a valid/ready handshake. It assembles 32-bit words,
// writes them into instruction memory, and holds the core in reset until the
// image is complete.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   reset      synchronous active-low reset
//   in_valid   source has a byte on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   reload     single-cycle reload request, honoured only while running
//   mem_wr     instruction-memory write strobe, one cycle per word
//   mem_addr   word address of the write
//   mem_wdata  assembled instruction word
//   core_reset 1 holds the core at PC 0
//   done       image loaded, core running
//   error      header length exceeded the memory depth; cleared only by reset
module prog_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  // 17 bits so a depth of 2**16 words still compares correctly.
  localparam logic [16:0] DepthLen = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StRun,
    StErr
  } state_e;

  state_e              state_q;
  logic [15:0]         count_q;
  logic [1:0]          byte_idx_q;
  logic [15:0]         word_idx_q;
  logic [31:0]         word_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                xfer;
  logic [15:0]         len_full;

  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data, count_q[7:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StLenLo;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        StLenLo: begin
          if (xfer) begin
            count_q[7:0] <= in_data;
            state_q      <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            count_q[15:8] <= in_data;
            if (len_full == 16'd0) begin
              state_q <= StRun;
            end else if ({1'b0, len_full} > DepthLen) begin
              state_q <= StErr;
            end else begin
              byte_idx_q <= '0;
              word_idx_q <= '0;
              state_q    <= StData;
            end
          end
        end
        StData: begin
          // The address is only ever presented during the following WRITE
          // cycle; word_idx cannot move while collecting bytes.
          addr_q <= word_idx_q[ADDR_W-1:0];
          if (xfer) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          if (word_idx_q == count_q - 16'd1) begin
            state_q <= StRun;
          end else begin
            word_idx_q <= word_idx_q + 16'd1;
            state_q    <= StData;
          end
        end
        StRun: begin
          if (reload) begin
            count_q    <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            state_q    <= StLenLo;
          end
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          state_q <= StLenLo;
        end
      endcase
    end
  end

  // All control outputs decode from the registered state only.
  assign in_ready   = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign mem_wr     = (state_q == StWrite);
  assign core_reset = (state_q != StRun);
  assign done       = (state_q == StRun);
  assign error      = (state_q == StErr);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  first_cyc = 0;
  bit  run_chk  = 1'b0;
  wr_t exp_q[$];
  wr_t wlog[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Model: derive the expected memory writes straight from the stream format.
  task automatic model(input bytes_t s);
    int n;
    wr_t w;
    n = int'(s[0]) | (int'(s[1]) << 8);
    if (n > 0 && n <= DEPTH) begin
      for (int k = 0; k < n; k++) begin
        if (2 + 4 * k + 3 < s.size()) begin
          w.addr = k;
          w.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // Compare process: every write must be the next one the model expects.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("done_vs_core_reset", {31'd0, done}, {31'd0, ~core_reset});
      if (error) chk("err_core_reset", {31'd0, core_reset}, 32'd1);
      if (mem_wr) begin
        chk("wr_in_ready", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", {31'd0, mem_wr}, 32'd0);
        end else begin
          wr_t e;
          wr_t g;
          e = exp_q.pop_front();
          g.addr = mem_addr;
          g.data = mem_wdata;
          wlog.push_back(g);
          chk("wr_addr", 32'(mem_addr), e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive bytes on negedges; a byte is consumed at the next posedge if
  // in_ready is high (it only changes on posedges).
  task automatic send(input bytes_t q, input bit toggle);
    int  i = 0;
    int  n = 0;
    bit  ph = 1'b0;
    while (i < q.size() && n < 400) begin
      @(negedge clk);
      if (n == 0) first_cyc = cyc;
      n++;
      if (toggle && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = q[i];
        if (in_ready) i++;
      end
      ph = ~ph;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("send_progress", i, q.size());
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  bytes_t s;
  int     t_done;

  initial begin
    do_reset();
    run_chk = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);

    // Nominal load with in_valid held.
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    model(s);
    chk("model_w0", exp_q[0].data, 32'h00A00513);
    chk("model_w1", exp_q[1].data, 32'h00150593);
    wlog.delete();
    send(s, 1'b0);
    chk("nom_not_done_in_write", {31'd0, done}, 32'd0);
    wait_done(t_done);
    chk("nom_latency", t_done - first_cyc, 12);
    chk("nom_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("nom_log_a1", wlog[1].addr, 32'd1);
      chk("nom_log_d1", wlog[1].data, 32'h00150593);
    end
    chk("nom_queue_empty", exp_q.size(), 0);
    chk("nom_core_reset", {31'd0, core_reset}, 32'd0);

    // Stalled source.
    do_reset();
    model(s);
    wlog.delete();
    send(s, 1'b1);
    wait_done(t_done);
    chk("stall_writes", wlog.size(), 2);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Zero length.
    do_reset();
    s = '{8'h00, 8'h00};
    model(s);
    wlog.delete();
    send(s, 1'b0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_core_reset", {31'd0, core_reset}, 32'd0);
    chk("zero_no_wr", wlog.size(), 0);

    // Reload from RUN, then a fresh image overwrites addr 0.
    pulse_reload();
    chk("reload_core_reset", {31'd0, core_reset}, 32'd1);
    chk("reload_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    model(s);
    chk("model_reload_w0", exp_q[0].data, 32'h12345678);
    send(s, 1'b0);
    wait_done(t_done);
    chk("reload_queue_empty", exp_q.size(), 0);

    // Reload during DATA is ignored.
    pulse_reload();
    model(s);
    send('{8'h01, 8'h00, 8'h78, 8'h56}, 1'b0);
    pulse_reload();
    chk("data_reload_in_ready", {31'd0, in_ready}, 32'd1);
    chk("data_reload_done", {31'd0, done}, 32'd0);
    send('{8'h34, 8'h12}, 1'b0);
    wait_done(t_done);
    chk("data_reload_queue_empty", exp_q.size(), 0);

    // Oversize header.
    do_reset();
    s = '{8'h01, 8'h10};
    model(s);
    send(s, 1'b0);
    chk("over_error", {31'd0, error}, 32'd1);
    chk("over_in_ready", {31'd0, in_ready}, 32'd0);
    chk("over_core_reset", {31'd0, core_reset}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("over_error_sticky", {31'd0, error}, 32'd1);
    do_reset();
    chk("over_reset_clears", {31'd0, error}, 32'd0);
    chk("over_reset_ready", {31'd0, in_ready}, 32'd1);

    // N == DEPTH is legal.
    send('{8'h00, 8'h10}, 1'b0);
    chk("depth_no_error", {31'd0, error}, 32'd0);
    chk("depth_in_ready", {31'd0, in_ready}, 32'd1);
    chk("depth_core_reset", {31'd0, core_reset}, 32'd1);

    // Reset mid-word, then a fresh single-word load.
    do_reset();
    wlog.delete();
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    model(s);
    send(s, 1'b0);
    do_reset();
    chk("midword_no_wr", wlog.size(), 0);
    chk("midword_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midword_core_reset", {31'd0, core_reset}, 32'd1);
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model(s);
    chk("model_mid_w0", exp_q[0].data, 32'h44332211);
    send(s, 1'b0);
    wait_done(t_done);
    chk("midword_writes", wlog.size(), 1);
    chk("midword_queue_empty", exp_q.size(), 0);

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle RV32I core and its instruction memory. Receives a byte stream (length header plus little-endian instruction words) over a valid/ready handshake, assembles 32-bit words, and writes them into instruction memory. Holds the core in reset until the image is complete, then releases it. A reload request returns it to loading.

## Interface
Parameters:
- ADDR_W, 12, instruction-memory word-address width; matches the core's PC[13:2] indexing; DEPTH = 2**ADDR_W words

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
- in_valid  input  1  byte source has a byte on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready
- reload  input  1  single-cycle request to reload; honoured only in RUN
- mem_wr  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  assembled instruction word
- core_reset  output  1  active-high hold for the core (1 = core held at PC 0)
- done  output  1  image loaded, core running
- error  output  1  header length exceeded DEPTH; sticky until reset

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes; each word is LSB byte first.
- States: LEN_LO, LEN_HI, DATA, WRITE, RUN, ERR. Reset enters LEN_LO.
- LEN_LO: in_ready=1; on transfer, latch count[7:0] and go to LEN_HI.
- LEN_HI: in_ready=1; on transfer, latch count[15:8] and evaluate N={in_data,count[7:0]}:
  - N==0: go to RUN.
  - N>DEPTH: go to ERR.
  - otherwise: clear byte_idx and word_idx, then go to DATA.
- DATA: in_ready=1; on transfer, store in_data into word byte lane byte_idx and increment byte_idx (2 bits). On the transfer with byte_idx==3, go to WRITE.
- WRITE: in_ready=0, mem_wr=1, mem_addr=word_idx[ADDR_W-1:0], mem_wdata=assembled word.
  - Next cycle: if word_idx==N-1, go to RUN.
  - Else increment word_idx and return to DATA.
- RUN: in_ready=0, core_reset=0, done=1. reload=1 returns to LEN_LO; count, byte_idx and word_idx are cleared. Memory contents are untouched and are overwritten by the next load.
- ERR: in_ready=0, core_reset=1, error=1. Only reset exits.
- Width rules:
  - word_idx is 16 bits; comparisons use the full 16-bit N.
  - N==DEPTH is legal and fills the memory exactly; mem_addr never wraps.
- In every state other than RUN, core_reset=1 and done=0.
- in_valid while in_ready=0: the byte is not consumed; the source must hold it.
- reload outside RUN is ignored.

## Timing
- Reset values (all outputs, cycle after reset sampled 0): in_ready=1 (LEN_LO), mem_wr=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0.
- Reset mid-load abandons the partial word and returns to LEN_LO. Words already written stay in memory.
- in_ready, mem_wr, core_reset, done and error decode from the registered state only; no combinational path from in_valid.
- mem_addr and mem_wdata are registered and stable during the WRITE cycle.
- Per-word cost is at least 5 cycles (4 byte transfers + 1 WRITE cycle). Back-to-back valid bytes are accepted every cycle in LEN_LO, LEN_HI and DATA.
- Last word: WRITE at cycle t, then core_reset=0 and done=1 at t+1. The core's first fetch sees the completed memory.
- RUN with reload=1 at edge t: core_reset=1 and in_ready=1 from t+1.

## Test plan
- Nominal load: reset, stream 02 00 | 13 05 A0 00 | 93 05 15 00 with in_valid held.
  - mem_wr pulses twice: addr 0 data 0x00A00513, then addr 1 data 0x00150593.
  - core_reset falls and done rises one cycle after the second write; 12 total cycles from first byte to RUN edge.
- Stalled source: same stream with in_valid toggling 1/0 each cycle.
  - Identical writes; no byte lost or duplicated.
  - in_ready=0 during both WRITE cycles.
- Zero length: stream 00 00.
  - No mem_wr; done=1 and core_reset=0 the cycle after LEN_HI transfer.
- Oversize: ADDR_W=12, stream 01 10 (N=4097).
  - error=1, in_ready=0, core_reset=1; further bytes ignored; reset clears error.
- Reset mid-word: after header 01 00 and bytes AA BB, assert reset one cycle.
  - No mem_wr; state LEN_LO, in_ready=1, core_reset=1.
  - A fresh 01 00 | 11 22 33 44 writes 0x44332211 to addr 0.
- Reload: in RUN, pulse reload, then stream 01 00 | 78 56 34 12.
  - core_reset=1 the cycle after reload; addr 0 overwritten with 0x12345678; done reasserts after the write.
  - A reload pulse during DATA has no effect.
